// File: rtl/simple_rx.sv
// simple_rx: GMII-style frame receiver feeding an AXI4-Stream consumer.
// Parses SFD/TYPE/SIZE/payload/FCS, stages the payload speculatively in a
// circular buffer and releases only frames whose FCS checks out.
module simple_rx #(
   parameter int G_MEM_SIZE = 512
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  rxd_in,
   input  logic        rxdv_in,
   input  logic        rxer_in,
   output logic [7:0]  tdata_out,
   output logic        tvalid_out,
   output logic        tlast_out,
   input  logic        tready_in,
   output logic [15:0] stat_packet_vld_cnt,
   output logic [15:0] stat_packet_err_cnt
);

   localparam int AW = $clog2(G_MEM_SIZE);

   // One extra pointer bit separates a full buffer from an empty one.
   typedef logic [AW:0] ptr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SFD,
      ST_TYPE,
      ST_SIZE,
      ST_PAYLOAD,
      ST_FCS,
      ST_DROP
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] fcs, fcs_nxt;
   logic [7:0] size_q, size_nxt;
   logic       rxdv_q;
   logic       frame_ok, frame_bad;
   logic       wr_en, wr_last;
   logic       acc_q, rej_q;
   ptr_t       wr_ptr, commit_ptr, rd_ptr, free_space;
   logic [8:0] mem [G_MEM_SIZE];

   assign free_space = ptr_t'(G_MEM_SIZE) - (wr_ptr - rd_ptr);

   // Next-state, byte counting, checksum and write-strobe decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fcs_nxt   = fcs;
      size_nxt  = size_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      wr_en     = 1'b0;
      wr_last   = 1'b0;
      case (state)
         // A frame starts only on a fresh rxdv assertion, so trailing bytes
         // after an accepted FCS (rxdv still high) are ignored here.
         ST_IDLE: begin
            if (rxdv_in && !rxdv_q) begin
               fcs_nxt = '0;
               cnt_nxt = 8'd1;
               if (rxer_in || rxd_in != 8'h55) begin
                  frame_bad = 1'b1;
                  state_nxt = ST_DROP;
               end else begin
                  state_nxt = ST_SFD;
               end
            end
         end
         ST_DROP: begin
            if (!rxdv_in) state_nxt = ST_IDLE;
         end
         default: begin
            if (!rxdv_in) begin
               frame_bad = 1'b1;
               state_nxt = ST_IDLE;
            end else if (rxer_in) begin
               frame_bad = 1'b1;
               state_nxt = ST_DROP;
            end else begin
               case (state)
                  ST_SFD: begin
                     if (rxd_in != ((cnt == 8'd3) ? 8'h7F : 8'h55)) begin
                        frame_bad = 1'b1;
                        state_nxt = ST_DROP;
                     end else if (cnt == 8'd3) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_TYPE;
                     end else begin
                        cnt_nxt = cnt + 8'd1;
                     end
                  end
                  ST_TYPE: begin
                     if (rxd_in != ((cnt == 8'd0) ? 8'h12 : 8'h34)) begin
                        frame_bad = 1'b1;
                        state_nxt = ST_DROP;
                     end else begin
                        fcs_nxt = fcs + rxd_in;
                        if (cnt == 8'd1) begin
                           cnt_nxt   = '0;
                           state_nxt = ST_SIZE;
                        end else begin
                           cnt_nxt = cnt + 8'd1;
                        end
                     end
                  end
                  ST_SIZE: begin
                     if (rxd_in < 8'd8 || ptr_t'(rxd_in) > free_space) begin
                        frame_bad = 1'b1;
                        state_nxt = ST_DROP;
                     end else begin
                        size_nxt  = rxd_in;
                        fcs_nxt   = fcs + rxd_in;
                        cnt_nxt   = '0;
                        state_nxt = ST_PAYLOAD;
                     end
                  end
                  ST_PAYLOAD: begin
                     wr_en   = 1'b1;
                     fcs_nxt = fcs + rxd_in;
                     if (cnt == size_q - 8'd1) begin
                        wr_last   = 1'b1;
                        state_nxt = ST_FCS;
                     end else begin
                        cnt_nxt = cnt + 8'd1;
                     end
                  end
                  ST_FCS: begin
                     if (rxd_in == fcs) begin
                        frame_ok  = 1'b1;
                        state_nxt = ST_IDLE;
                     end else begin
                        frame_bad = 1'b1;
                        state_nxt = ST_DROP;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Parser state registers; rxdv_q resets high so a frame cut by reset is not resumed.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         fcs    <= '0;
         size_q <= '0;
         rxdv_q <= 1'b1;
         acc_q  <= 1'b0;
         rej_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         fcs    <= fcs_nxt;
         size_q <= size_nxt;
         rxdv_q <= rxdv_in;
         acc_q  <= frame_ok;
         rej_q  <= frame_bad;
      end
   end

   // Speculative write pointer and commit pointer.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
      end else begin
         if (frame_bad)  wr_ptr <= commit_ptr;
         else if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
         if (frame_ok)   commit_ptr <= wr_ptr;
      end
   end

   // Payload buffer write port: {last, data}.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, rxd_in};
   end

   // Stream output register; refills whenever empty or being consumed.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr     <= '0;
         tvalid_out <= 1'b0;
         tdata_out  <= '0;
         tlast_out  <= 1'b0;
      end else if (!tvalid_out || tready_in) begin
         if (rd_ptr != commit_ptr) begin
            tdata_out  <= mem[rd_ptr[AW-1:0]][7:0];
            tlast_out  <= mem[rd_ptr[AW-1:0]][8];
            tvalid_out <= 1'b1;
            rd_ptr     <= rd_ptr + ptr_t'(1);
         end else begin
            tvalid_out <= 1'b0;
         end
      end
   end

   // Frame statistics, one cycle after the verdict.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stat_packet_vld_cnt <= '0;
         stat_packet_err_cnt <= '0;
      end else begin
         if (acc_q) stat_packet_vld_cnt <= stat_packet_vld_cnt + 16'd1;
         if (rej_q) stat_packet_err_cnt <= stat_packet_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_simple_rx.sv
// tb_simple_rx: table vectors, hand sequences and randomized frames checked
// against a frame-level reference model and payload scoreboard.
module tb_simple_rx;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic [7:0]  rxd = '0;
   logic        rxdv = 1'b0, rxer = 1'b0;
   logic        tready_a = 1'b0, tready_b = 1'b0;
   logic [7:0]  tdata_a, tdata_b;
   logic        tvalid_a, tvalid_b, tlast_a, tlast_b;
   logic [15:0] vld_a, err_a, vld_b, err_b;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] frm [$];
   logic [8:0] sb_a [$];
   logic [8:0] sb_b [$];
   int         xfer = 0;
   int         last_cnt = 0;
   bit         rand_rdy = 1'b0;

   simple_rx #(.G_MEM_SIZE(512)) dut_a (
      .clk_in(clk), .rst_in(rst_a), .rxd_in(rxd), .rxdv_in(rxdv), .rxer_in(rxer),
      .tdata_out(tdata_a), .tvalid_out(tvalid_a), .tlast_out(tlast_a), .tready_in(tready_a),
      .stat_packet_vld_cnt(vld_a), .stat_packet_err_cnt(err_a)
   );

   simple_rx #(.G_MEM_SIZE(256)) dut_b (
      .clk_in(clk), .rst_in(rst_b), .rxd_in(rxd), .rxdv_in(rxdv), .rxer_in(rxer),
      .tdata_out(tdata_b), .tvalid_out(tvalid_b), .tlast_out(tlast_b), .tready_in(tready_b),
      .stat_packet_vld_cnt(vld_b), .stat_packet_err_cnt(err_b)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Builds a frame in frm; FCS is the mod-256 sum of type, size and payload.
   task automatic build_frame(input logic [31:0] sfd, input logic [15:0] typ, input logic [7:0] n,
                              input logic [7:0] seed, input logic [7:0] fcs_add);
      logic [7:0] s;
      frm.delete();
      frm.push_back(sfd[31:24]);
      frm.push_back(sfd[23:16]);
      frm.push_back(sfd[15:8]);
      frm.push_back(sfd[7:0]);
      frm.push_back(typ[15:8]);
      frm.push_back(typ[7:0]);
      frm.push_back(n);
      s = typ[15:8] + typ[7:0] + n;
      for (int i = 0; i < int'(n); i++) begin
         frm.push_back(seed + 8'(i));
         s = s + seed + 8'(i);
      end
      frm.push_back(s + fcs_add);
   endtask

   // Reference verdict from the frame rules; free space uses bytes not yet consumed.
   function automatic bit judge(input int rxer_at, input int mem, input int pending);
      int n;
      logic [7:0] s;
      if (frm.size() < 7) return 1'b0;
      if (frm[0] != 8'h55 || frm[1] != 8'h55 || frm[2] != 8'h55 || frm[3] != 8'h7F) return 1'b0;
      if (frm[4] != 8'h12 || frm[5] != 8'h34) return 1'b0;
      n = int'(frm[6]);
      if (n < 8 || n > mem - pending) return 1'b0;
      if (frm.size() < 8 + n) return 1'b0;
      if (rxer_at >= 0 && rxer_at <= 7 + n) return 1'b0;
      s = '0;
      for (int i = 4; i <= 6 + n; i++) s = s + frm[i];
      return s == frm[7 + n];
   endfunction

   task automatic push_payload(input bit to_b);
      int n;
      n = int'(frm[6]);
      for (int i = 0; i < n; i++) begin
         if (to_b) sb_b.push_back({(i == n - 1), frm[7 + i]});
         else      sb_a.push_back({(i == n - 1), frm[7 + i]});
      end
   endtask

   task automatic drive_frame(input int rxer_at, input int gap);
      for (int i = 0; i < frm.size(); i++) begin
         rxd  = frm[i];
         rxdv = 1'b1;
         rxer = (rxer_at >= 0 && i >= rxer_at);
         if (rand_rdy) tready_a = ($urandom % 4) != 0;
         tick();
      end
      rxdv = 1'b0;
      rxer = 1'b0;
      rxd  = '0;
      for (int g = 0; g < gap; g++) begin
         if (rand_rdy) tready_a = ($urandom % 4) != 0;
         tick();
      end
   endtask

   // Stream monitor for instance A: ordering, tlast and hold stability.
   initial begin
      logic       hold_v;
      logic [8:0] hold_d;
      logic [8:0] e;
      hold_v = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (rst_a) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("hold_valid", 32'(tvalid_a), 32'd1);
               check("hold_data", 32'({tlast_a, tdata_a}), 32'(hold_d));
            end
            if (tvalid_a && tready_a) begin
               xfer++;
               if (tlast_a) last_cnt++;
               if (sb_a.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL stream_extra: got 0x%0h, required no byte", {tlast_a, tdata_a});
               end else begin
                  e = sb_a.pop_front();
                  check("stream_a", 32'({tlast_a, tdata_a}), 32'(e));
               end
            end
            hold_v = tvalid_a && !tready_a;
            hold_d = {tlast_a, tdata_a};
         end
      end
   end

   typedef struct {
      logic [31:0] sfd;
      logic [15:0] typ;
      logic [7:0]  size;
      logic [7:0]  fcs_add;
      int          rxer_at;
      bit          exp_ok;
   } vec_t;

   vec_t vt [15];

   initial begin
      int         exp_vld, exp_err, n, kind, gap, got, c;
      bit         ok;
      int         rx_at;
      logic [7:0] first_byte, bad;
      logic [8:0] e;

      // Tests 1-6, then the nine-frame sequence of test 7.
      vt[0]  = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};
      vt[1]  = '{32'h2244557F, 16'h1234, 8'd10, 8'h00, -1, 1'b0};
      vt[2]  = '{32'h5555557F, 16'hAA34, 8'd10, 8'h00, -1, 1'b0};
      vt[3]  = '{32'h5555557F, 16'h1234, 8'd3,  8'h00, -1, 1'b0};
      vt[4]  = '{32'h5555557F, 16'h1234, 8'd10, 8'hFF, -1, 1'b0};
      vt[5]  = '{32'h5555557F, 16'h1234, 8'd10, 8'h00,  6, 1'b0};
      vt[6]  = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};
      vt[7]  = '{32'h2244557F, 16'h1234, 8'd10, 8'h00, -1, 1'b0};
      vt[8]  = '{32'h5555557F, 16'hAA34, 8'd10, 8'h00, -1, 1'b0};
      vt[9]  = '{32'h5555557F, 16'h1234, 8'd3,  8'h00, -1, 1'b0};
      vt[10] = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};
      vt[11] = '{32'h5555557F, 16'h1234, 8'd10, 8'h00,  6, 1'b0};
      vt[12] = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};
      vt[13] = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};
      vt[14] = '{32'h5555557F, 16'h1234, 8'd10, 8'h00, -1, 1'b1};

      repeat (3) tick();
      rst_a = 1'b0;
      tick();
      check("rst_tvalid", 32'(tvalid_a), 32'd0);
      check("rst_tlast", 32'(tlast_a), 32'd0);
      check("rst_tdata", 32'(tdata_a), 32'd0);
      check("rst_vld", 32'(vld_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);

      exp_vld = 0;
      exp_err = 0;
      first_byte = '0;
      for (int i = 0; i < 6; i++) begin
         build_frame(vt[i].sfd, vt[i].typ, vt[i].size, 8'(i * 16 + 1), vt[i].fcs_add);
         if (vt[i].exp_ok) begin
            push_payload(1'b0);
            exp_vld++;
         end else begin
            exp_err++;
         end
         if (i == 0) begin
            first_byte = frm[7];
            drive_frame(vt[i].rxer_at, 0);
            check("vld_at_fcs_edge", 32'(vld_a), 32'd0);
            tick();
            check("vld_next_edge", 32'(vld_a), 32'd1);
            tick();
            tick();
            check("tvalid_after_commit", 32'(tvalid_a), 32'd1);
            check("first_tdata", 32'(tdata_a), 32'(first_byte));
            check("first_tlast", 32'(tlast_a), 32'd0);
            tick();
         end else begin
            drive_frame(vt[i].rxer_at, 3);
            check("no_new_data_valid", 32'(tvalid_a), 32'd1);
            check("no_new_data", 32'(tdata_a), 32'(first_byte));
         end
         check("vec_vld", 32'(vld_a), 32'(exp_vld));
         check("vec_err", 32'(err_a), 32'(exp_err));
      end

      // Test 7: back-to-back sequence with single-cycle gaps.
      rst_a = 1'b1;
      sb_a.delete();
      tick();
      rst_a = 1'b0;
      tick();
      exp_vld = 0;
      exp_err = 0;
      for (int i = 6; i < 15; i++) begin
         build_frame(vt[i].sfd, vt[i].typ, vt[i].size, 8'(i * 16 + 1), vt[i].fcs_add);
         if (vt[i].exp_ok) begin
            push_payload(1'b0);
            exp_vld++;
         end else begin
            exp_err++;
         end
         drive_frame(vt[i].rxer_at, 1);
      end
      repeat (3) tick();
      check("seq_vld", 32'(vld_a), 32'd5);
      check("seq_err", 32'(err_a), 32'd4);
      xfer = 0;
      last_cnt = 0;
      tready_a = 1'b1;
      for (c = 0; c < 200 && xfer < 50; c++) tick();
      tick();
      check("seq_bytes", 32'(xfer), 32'd50);
      check("seq_tlast_count", 32'(last_cnt), 32'd5);
      check("seq_drained", 32'(sb_a.size()), 32'd0);
      check("seq_tvalid_low", 32'(tvalid_a), 32'd0);

      // Randomized frames against the reference model.
      exp_vld = 5;
      exp_err = 4;
      rand_rdy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(4, 20);
         build_frame(32'h5555557F, 16'h1234, 8'(n), 8'($urandom), 8'h00);
         kind = $urandom % 8;
         rx_at = -1;
         case (kind)
            0: begin
               bad = 8'h01;
               bad = bad << ($urandom % 8);
               c = $urandom % 4;
               frm[c] = frm[c] ^ bad;
            end
            1: begin
               c = 4 + ($urandom % 2);
               frm[c] = frm[c] ^ 8'h80;
            end
            2: frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'($urandom_range(1, 255));
            3: rx_at = $urandom_range(0, frm.size() - 1);
            4: begin
               c = $urandom_range(1, frm.size() - 1);
               while (frm.size() > c) void'(frm.pop_back());
            end
            5: begin
               c = $urandom_range(1, 3);
               for (int j = 0; j < c; j++) frm.push_back(8'($urandom));
            end
            default: ;
         endcase
         ok = judge(rx_at, 512, sb_a.size());
         if (ok) begin
            push_payload(1'b0);
            exp_vld++;
         end else begin
            exp_err++;
         end
         gap = $urandom_range(1, 3);
         drive_frame(rx_at, gap);
         if (gap == 3) begin
            check("rand_vld", 32'(vld_a), 32'(exp_vld));
            check("rand_err", 32'(err_a), 32'(exp_err));
         end
      end
      rand_rdy = 1'b0;
      tready_a = 1'b1;
      for (c = 0; c < 500 && sb_a.size() > 0; c++) tick();
      repeat (3) tick();
      check("rand_drained", 32'(sb_a.size()), 32'd0);
      check("rand_final_vld", 32'(vld_a), 32'(exp_vld));
      check("rand_final_err", 32'(err_a), 32'(exp_err));
      check("rand_tvalid_low", 32'(tvalid_a), 32'd0);

      // Test 8: 256-byte buffer fills, no overwrite, then reset mid-frame.
      rst_a = 1'b1;
      tick();
      rst_b = 1'b0;
      tready_b = 1'b0;
      tick();
      check("b_rst_vld", 32'(vld_b), 32'd0);
      check("b_rst_tvalid", 32'(tvalid_b), 32'd0);
      for (int k = 0; k < 30; k++) begin
         build_frame(32'h5555557F, 16'h1234, 8'd10, 8'(k * 7), 8'h00);
         if (judge(-1, 256, sb_b.size())) push_payload(1'b1);
         drive_frame(-1, 1);
      end
      repeat (3) tick();
      check("full_vld", 32'(vld_b), 32'd25);
      check("full_err", 32'(err_b), 32'd5);
      check("full_tvalid", 32'(tvalid_b), 32'd1);
      check("full_first_byte", 32'(tdata_b), 32'd0);
      tready_b = 1'b1;
      got = 0;
      for (c = 0; c < 400 && sb_b.size() > 0; c++) begin
         @(negedge clk);
         if (tvalid_b) begin
            e = sb_b.pop_front();
            check("stream_b", 32'({tlast_b, tdata_b}), 32'(e));
            got++;
         end
      end
      tick();
      check("full_drain_bytes", 32'(got), 32'd250);

      tready_b = 1'b0;
      build_frame(32'h5555557F, 16'h1234, 8'd12, 8'hA0, 8'h00);
      drive_frame(-1, 3);
      check("pre_abort_vld", 32'(vld_b), 32'd26);
      check("pre_abort_tvalid", 32'(tvalid_b), 32'd1);
      build_frame(32'h5555557F, 16'h1234, 8'd12, 8'hB0, 8'h00);
      for (int i = 0; i < 9; i++) begin
         rxd = frm[i];
         rxdv = 1'b1;
         tick();
      end
      rst_b = 1'b1;
      rxdv = 1'b0;
      rxd = '0;
      tick();
      rst_b = 1'b0;
      check("abort_vld", 32'(vld_b), 32'd0);
      check("abort_err", 32'(err_b), 32'd0);
      check("abort_tvalid", 32'(tvalid_b), 32'd0);
      check("abort_tdata", 32'(tdata_b), 32'd0);
      check("abort_tlast", 32'(tlast_b), 32'd0);
      repeat (3) tick();
      check("abort_silent_err", 32'(err_b), 32'd0);
      build_frame(32'h5555557F, 16'h1234, 8'd8, 8'hC0, 8'h00);
      drive_frame(-1, 3);
      check("post_abort_vld", 32'(vld_b), 32'd1);
      check("post_abort_err", 32'(err_b), 32'd0);
      check("post_abort_tvalid", 32'(tvalid_b), 32'd1);
      check("post_abort_tdata", 32'(tdata_b), 32'hC0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/simple_rx.md
# simple_rx

Byte-stream frame receiver between a GMII-style 8-bit PHY receive interface and an AXI4-Stream consumer. It parses each frame (SFD, type, size, payload, checksum), buffers the payload in an internal circular memory, and releases only validated payloads on the stream output. Failed frames are discarded. It keeps 16-bit counts of accepted and rejected frames.

## Interface
- G_MEM_SIZE, 512: payload buffer depth in bytes; power of two, at least 256.
- clk_in  in  1  single clock; all logic on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rxd_in  in  8  receive data byte, sampled when rxdv_in=1.
- rxdv_in  in  1  receive data valid; high for the whole frame.
- rxer_in  in  1  receive error; any sample at 1 while rxdv_in=1 corrupts the frame.
- tdata_out  out  8  payload byte.
- tvalid_out  out  1  AXI-Stream valid.
- tlast_out  out  1  high on the last payload byte of a frame.
- tready_in  in  1  AXI-Stream ready.
- stat_packet_vld_cnt  out  16  number of frames accepted.
- stat_packet_err_cnt  out  16  number of frames rejected.

## Operation
- Frame on rxd_in, in byte order:
  - SFD 0x55, 0x55, 0x55, 0x7F.
  - TYPE 0x12 then 0x34.
  - SIZE: one byte N.
  - N payload bytes.
  - FCS.
  - Then rxdv_in falls.
- FCS = (0x12 + 0x34 + N + Σpayload) mod 256. Accumulate in an 8-bit register that wraps; reset it at frame start.
- FSM states: IDLE, SFD, TYPE, SIZE, PAYLOAD, FCS, DROP.
- Transitions:
  - IDLE → SFD on the first sample with rxdv_in=1; that byte is SFD byte 0.
  - SFD → TYPE → SIZE → PAYLOAD → FCS, with byte counters in each state.
  - FCS → IDLE after the FCS byte is judged.
  - DROP → IDLE when rxdv_in=0.
- Rejection causes; each sends the FSM to DROP:
  - any SFD byte mismatch;
  - TYPE ≠ 0x1234;
  - N < 8;
  - N greater than the free buffer space;
  - rxer_in=1 while rxdv_in=1;
  - rxdv_in falling before the FCS byte;
  - FCS mismatch.
- Each rejected frame increments stat_packet_err_cnt exactly once.
- Bytes arriving after a judged FCS, before rxdv_in falls, are ignored.
- Buffer:
  - Entries are 9 bits: {last, data}.
  - Payload bytes are written at a speculative write pointer, with last set on byte N.
  - On accept, the commit pointer is loaded from the speculative pointer and stat_packet_vld_cnt increments.
  - On reject, the speculative pointer is restored to the commit pointer.
  - Pointers wrap modulo G_MEM_SIZE.
  - Free space = G_MEM_SIZE − (speculative − read), computed at SIZE.
- Output:
  - The read side streams only committed entries (read ≠ commit).
  - A byte transfers when tvalid_out & tready_in are both 1.
  - tdata_out and tlast_out stay stable while tvalid_out=1 and tready_in=0.
- Counters wrap at 0xFFFF → 0.

## Timing
- Reset values:
  - tvalid_out=0, tlast_out=0, tdata_out=0x00.
  - Both counters 0; all pointers 0; FSM in IDLE.
- Reset mid-frame aborts the frame silently; no counter increments.
- Back-to-back frames separated by a single rxdv_in=0 cycle must be received.
- A counter increments on the clock edge after the edge that samples the FCS byte, or after the edge that detects the error.
- tvalid_out rises no later than 3 cycles after the commit.
- Full throughput: with tready_in held at 1, one byte per cycle.
- Same-cycle commit and read are legal and must not lose entries.

## Test plan
- Test 1: frame 55 55 55 7F 12 34 0A + 10 bytes + correct FCS, tready_in=0.
  - Required: vld=1, err=0, tvalid_out=1 with the first payload byte.
- Test 2: SFD 22 44 55 7F.
  - Required: err+1, no new data.
- Test 3: TYPE AA 34.
  - Required: err+1.
- Test 4: SIZE 0x03.
  - Required: err+1.
- Test 5: FCS+0xFF.
  - Required: err+1.
- Test 6: rxer_in=1 from the SIZE byte onward.
  - Required: err+1.
- Test 7: full sequence of 9 frames (good, bad SFD, bad type, bad size, good, rxer, good, good, good).
  - Required: vld=5, err=4.
  - Then raise tready_in and read 50 bytes; tlast_out=1 exactly on bytes 10, 20, 30, 40, 50.
  - Data matches the good payloads only, in order.
- Test 8: with G_MEM_SIZE=256, 30 good 10-byte frames, tready_in=0.
  - Required: first 25 accepted, remaining 5 counted as errors; no overwrite.
  - Assert rst_in mid-frame: counters and outputs return to 0.
